// File: rtl/pipe_hazard_ctrl.sv
// Issue/stall/flush controller: per-register pending-write scoreboard plus a
// RUN/FLUSH/HOLD sequencer that gates the IF/ID and ID/EX register enables.

module pipe_hazard_pend (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       dec,
   output logic [1:0] cnt,
   output logic       uflow
);
   // A writeback with nothing outstanding is flagged but leaves the count at 0.
   assign uflow = dec && !inc && (cnt == 2'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= 2'd0;
      else if (inc && !dec)
         cnt <= cnt + 2'd1;
      else if (dec && !inc && cnt != 2'd0)
         cnt <= cnt - 2'd1;
   end
endmodule

module pipe_hazard_ctrl #(
   parameter int NUM_REGS    = 4,
   parameter int REG_AW      = 2,
   parameter int FLUSH_DEPTH = 2,
   parameter int MAX_PEND    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_rd_wr,
   input  logic              ex_busy,
   input  logic              br_taken,
   input  logic              wb_wr,
   input  logic [REG_AW-1:0] wb_rd,
   output logic              issue,
   output logic              stall_if,
   output logic              flush_id,
   output logic [1:0]        state,
   output logic [15:0]       stall_cnt,
   output logic              sb_err
);
   typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, HOLD = 2'd2} st_t;

   st_t                        st;
   logic [2:0]                 fcnt;
   logic [NUM_REGS-1:0][1:0]   pend;
   logic [NUM_REGS-1:0]        inc, dec, uflow;
   logic                       raw, sat;

   // Counters are read before this cycle's writeback: no same-cycle bypass.
   assign raw = (id_rs1_used && pend[id_rs1] != 2'd0) ||
                (id_rs2_used && pend[id_rs2] != 2'd0);
   assign sat = id_rd_wr && (pend[id_rd] == 2'(MAX_PEND));

   assign issue    = !rst && id_valid && (st == RUN) && !ex_busy && !br_taken && !raw && !sat;
   assign stall_if = !rst && id_valid && !issue && (st != FLUSH);
   assign state    = st;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         assign inc[gi] = issue && id_rd_wr && (id_rd == REG_AW'(gi));
         assign dec[gi] = wb_wr && (wb_rd == REG_AW'(gi));
         pipe_hazard_pend u_pend (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc[gi]),
            .dec   (dec[gi]),
            .cnt   (pend[gi]),
            .uflow (uflow[gi])
         );
      end
   endgenerate

   // A taken branch wins from any state and restarts the flush window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= RUN;
         fcnt     <= 3'd0;
         flush_id <= 1'b0;
      end else if (br_taken) begin
         st       <= FLUSH;
         fcnt     <= 3'(FLUSH_DEPTH);
         flush_id <= 1'b1;
      end else begin
         case (st)
            RUN:  if (ex_busy) st <= HOLD;
            FLUSH: begin
               if (fcnt <= 3'd1) begin
                  st       <= ex_busy ? HOLD : RUN;
                  fcnt     <= 3'd0;
                  flush_id <= 1'b0;
               end else begin
                  fcnt <= fcnt - 3'd1;
               end
            end
            HOLD: if (!ex_busy) st <= RUN;
            default: st <= RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= 16'd0;
         sb_err    <= 1'b0;
      end else begin
         if (stall_if && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
         if (|uflow)
            sb_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scenarios followed by random traffic, all checked against a
// behavioural model of pending writes, flush window and hold condition.

module tb_pipe_hazard_ctrl;
   localparam int FD = 2;
   localparam int MP = 3;

   logic       clk, rst;
   logic       valid, r1u, r2u, rdwr, busy, br, wbw;
   logic [1:0] rs1, rs2, rd, wbrd;
   logic       issue, stall_if, flush_id, sb_err;
   logic [1:0] state;
   logic [15:0] stall_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model
   int m_pend[4];
   int m_fl;       // remaining flush cycles, 0 when not flushing
   bit m_hold;
   int m_stall;
   bit m_err;
   bit e_issue, e_stall;
   int e_state;

   pipe_hazard_ctrl #(.NUM_REGS(4), .REG_AW(2), .FLUSH_DEPTH(FD), .MAX_PEND(MP)) dut (
      .clk(clk), .rst(rst), .id_valid(valid), .id_rs1(rs1), .id_rs2(rs2),
      .id_rs1_used(r1u), .id_rs2_used(r2u), .id_rd(rd), .id_rd_wr(rdwr),
      .ex_busy(busy), .br_taken(br), .wb_wr(wbw), .wb_rd(wbrd),
      .issue(issue), .stall_if(stall_if), .flush_id(flush_id), .state(state),
      .stall_cnt(stall_cnt), .sb_err(sb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 4; i++) m_pend[i] = 0;
      m_fl = 0; m_hold = 0; m_stall = 0; m_err = 0;
   endtask

   task automatic idle();
      valid = 0; r1u = 0; r2u = 0; rdwr = 0; busy = 0; br = 0; wbw = 0;
      rs1 = 0; rs2 = 0; rd = 0; wbrd = 0;
   endtask

   task automatic instr(input logic [1:0] a, input logic au, input logic [1:0] b,
                        input logic bu, input logic [1:0] d, input logic dw);
      valid = 1; rs1 = a; r1u = au; rs2 = b; r2u = bu; rd = d; rdwr = dw;
   endtask

   // Let inputs settle, then compare every output against the model.
   task automatic settle();
      bit raw_h, sat_h;
      #1;
      e_state = (m_fl > 0) ? 1 : (m_hold ? 2 : 0);
      raw_h   = (r1u && m_pend[rs1] > 0) || (r2u && m_pend[rs2] > 0);
      sat_h   = rdwr && m_pend[rd] == MP;
      e_issue = !rst && valid && e_state == 0 && !busy && !br && !raw_h && !sat_h;
      e_stall = !rst && valid && !e_issue && e_state != 1;
      chk("issue",     issue,     e_issue);
      chk("stall_if",  stall_if,  e_stall);
      chk("state",     state,     e_state);
      chk("flush_id",  flush_id,  m_fl > 0);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("sb_err",    sb_err,    m_err);
   endtask

   task automatic tick();
      @(posedge clk);
      if (e_stall && m_stall < 65535) m_stall++;
      for (int r = 0; r < 4; r++) begin
         bit inc_r, dec_r;
         inc_r = e_issue && rdwr && rd == r;
         dec_r = wbw && wbrd == r;
         if (inc_r && !dec_r) m_pend[r]++;
         else if (dec_r && !inc_r) begin
            if (m_pend[r] == 0) m_err = 1;
            else m_pend[r]--;
         end
      end
      if (br) begin
         m_fl = FD; m_hold = 0;
      end else if (m_fl > 1) begin
         m_fl--;
      end else begin
         m_fl = 0; m_hold = busy;
      end
      #1;
   endtask

   initial begin
      bit prev_br;
      idle();
      m_reset();
      rst = 1;
      instr(2'd1, 1, 2'd2, 1, 2'd3, 1);
      #3;
      chk("rst_issue", issue, 1'b0);
      chk("rst_stall", stall_if, 1'b0);
      chk("rst_state", state, 2'd0);
      chk("rst_flush", flush_id, 1'b0);
      chk("rst_cnt",   stall_cnt, 16'd0);
      chk("rst_err",   sb_err, 1'b0);
      @(posedge clk); #1;
      rst = 0; idle();

      // RAW stall on R1 until its writeback
      instr(2'd0, 0, 2'd0, 0, 2'd1, 1); settle(); chk("raw_first_issue", issue, 1'b1); tick();
      instr(2'd1, 1, 2'd0, 0, 2'd0, 0); settle(); chk("raw_stall", stall_if, 1'b1); tick();
      settle(); tick();
      wbw = 1; wbrd = 2'd1; settle(); chk("raw_wb_cycle", issue, 1'b0); tick();
      wbw = 0; settle(); chk("raw_release", issue, 1'b1); chk("raw_cnt", stall_cnt, 16'd3); tick();

      // same-cycle inc/dec on R2
      instr(2'd0, 0, 2'd0, 0, 2'd2, 1); settle(); tick();
      wbw = 1; wbrd = 2'd2; settle(); chk("incdec_issue", issue, 1'b1); tick();
      idle(); wbw = 1; wbrd = 2'd2; settle(); tick();
      idle(); instr(2'd2, 1, 2'd0, 0, 2'd0, 0); settle(); chk("incdec_clear", issue, 1'b1);
      chk("incdec_err", sb_err, 1'b0); tick();

      // branch flush
      instr(2'd0, 0, 2'd0, 0, 2'd0, 0); br = 1; settle(); chk("br_issue", issue, 1'b0); tick();
      br = 0;
      for (int k = 0; k < FD; k++) begin
         settle(); chk("fl_state", state, 2'd1); chk("fl_id", flush_id, 1'b1);
         chk("fl_stall", stall_if, 1'b0); tick();
      end
      settle(); chk("fl_done", state, 2'd0); tick();

      // multi-cycle EX hold, then branch during HOLD
      busy = 1;
      for (int k = 0; k < 3; k++) begin
         br = (k == 2); settle(); chk("hold_issue", issue, 1'b0); chk("hold_stall", stall_if, 1'b1); tick();
      end
      br = 0; busy = 0; settle(); chk("hold_to_flush", state, 2'd1); tick();
      for (int k = 0; k < FD; k++) begin settle(); tick(); end

      // saturation on R3, then underflow
      for (int k = 0; k < 3; k++) begin
         instr(2'd0, 0, 2'd0, 0, 2'd3, 1); settle(); chk("sat_fill", issue, 1'b1); tick();
      end
      settle(); chk("sat_block", issue, 1'b0); tick();
      idle(); wbw = 1; wbrd = 2'd3;
      for (int k = 0; k < 4; k++) begin settle(); tick(); end
      wbw = 0; settle(); chk("uflow_err", sb_err, 1'b1); tick();
      settle(); chk("err_sticky", sb_err, 1'b1); tick();

      // async reset in the middle of a flush with pend[0] = 2
      instr(2'd0, 0, 2'd0, 0, 2'd0, 1); settle(); tick(); settle(); tick();
      idle(); br = 1; settle(); tick();
      br = 0; settle();
      rst = 1; #1;
      chk("arst_flush", flush_id, 1'b0);
      chk("arst_state", state, 2'd0);
      chk("arst_cnt",   stall_cnt, 16'd0);
      chk("arst_err",   sb_err, 1'b0);
      #1; rst = 0; m_reset();
      instr(2'd0, 1, 2'd0, 1, 2'd1, 0); settle(); chk("arst_pend", issue, 1'b1); tick();

      // random traffic
      prev_br = 0;
      for (int n = 0; n < 800; n++) begin
         int r;
         valid = ($urandom_range(3) != 0);
         rs1 = 2'($urandom); rs2 = 2'($urandom); rd = 2'($urandom);
         r1u = 1'($urandom); r2u = 1'($urandom); rdwr = 1'($urandom);
         busy = ($urandom_range(5) == 0);
         br = !prev_br && ($urandom_range(11) == 0);
         prev_br = br;
         r = int'($urandom_range(3));
         wbw = 0; wbrd = 2'(r);
         if ($urandom_range(1) == 1 && (m_pend[r] > 0 || $urandom_range(40) == 0)) wbw = 1;
         settle(); tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
